multi_shift_register: RTL and testbench
=======================================

Name: multi_shift_register

Overview:
- Parametrised, width-generic successor to the 4-bit multi-function register.
- Adds:
  - multi-bit shifts/rotates executed one bit per clock, with a busy/done handshake
  - carry/borrow flag
  - zero flag
  - optional saturating increment/decrement
- Sits in the datapath as a general-purpose accumulator/shift register driven by a controller FSM.

Parameters:
- WIDTH, 8: data width in bits (>= 2).
- AMT_W, 3: width of the shift-amount input; maximum shift is 2^AMT_W-1.
- SATURATE, 0: 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec clamp at all-ones/zero.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cl  in  1  clear command (highest priority; also aborts a shift in progress).
- ld  in  1  parallel load command.
- inc  in  1  increment command.
- dec  in  1  decrement command.
- sr  in  1  shift/rotate right command.
- sl  in  1  shift/rotate left command.
- rot  in  1  1 = rotate, 0 = shift; sampled with sr/sl.
- ir  in  1  serial fill bit entering the MSB on a right shift; sampled with sr.
- il  in  1  serial fill bit entering the LSB on a left shift; sampled with sl.
- amt  in  AMT_W  shift count; sampled with sr/sl.
- in  in  WIDTH  parallel load data.
- out  out  WIDTH  register contents.
- carry  out  1  registered carry/borrow/shifted-out bit.
- zero  out  1  combinational, 1 when out == 0.
- busy  out  1  registered, 1 while a multi-cycle shift is in progress.
- done  out  1  registered, one-cycle pulse on shift completion.

Behaviour:
- Reset (rst_n low, asynchronous, immediate): out=0, carry=0, busy=0, done=0, state=IDLE; zero therefore 1. Applies mid-shift as well, discarding the remaining count.
- Command priority in IDLE, evaluated at each rising edge: cl > ld > inc > dec > sr > sl. No command held: out and carry hold.
- done is 0 every cycle except the single cycle defined below.
- cl: out=0, carry=0. Single cycle.
- ld: out=in, carry=0. Single cycle.
- inc:
  - SATURATE=0: out=out+1 mod 2^WIDTH; carry=1 if out was all-ones, else 0.
  - SATURATE=1: at all-ones, out holds and carry=1.
- dec:
  - SATURATE=0: out=out-1 mod 2^WIDTH; carry=1 if out was 0 (borrow), else 0.
  - SATURATE=1: at 0, out holds and carry=1.
- sr/sl acceptance:
  - amt, rot, and the fill bit (ir for sr, il for sl) are captured on the accepting edge and held internally for the whole operation.
  - Later changes on those inputs have no effect.
- Single-bit step, right:
  - out = {fill, out[WIDTH-1:1]}; carry = old out[0].
  - fill = ir when rot=0, old out[0] when rot=1.
- Single-bit step, left:
  - out = {out[WIDTH-2:0], fill}; carry = old out[WIDTH-1].
  - fill = il when rot=0, old out[WIDTH-1] when rot=1.
- State machine, IDLE/SHIFT:
  - amt=N>=2: accepting edge performs step 1, remaining=N-1, go to SHIFT, busy=1. Each SHIFT edge performs one step and decrements remaining. The edge that performs step N returns to IDLE with busy=0, done=1.
  - amt=1: accepting edge performs the step, stays IDLE, busy stays 0, done=1 for the next cycle.
  - amt=0: no step, out and carry unchanged, done=1 for the next cycle, busy stays 0.
  - Latency: out reflects k steps after k edges; done is high for exactly one cycle, the cycle after the N-th step edge.
- During SHIFT:
  - cl aborts: out=0, carry=0, busy=0, done=0, state=IDLE.
  - ld/inc/dec/sr/sl are ignored and not queued.
- A new command may be accepted in the same cycle that done is high.
- Rotate by WIDTH returns the original value; shift by amt >= WIDTH fills completely with the fill bit.
- Wrap-around and saturation are exactly as defined above; there is no other overflow signalling.

Test Plan (WIDTH=8, AMT_W=3):
1. Reset mid-shift:
   - Stimulus: ld 0xA5, then sr amt=5 rot=0 ir=0; deassert rst_n after 2 cycles.
   - Required response: out=0x00, busy=0, done=0, carry=0, zero=1 immediately; no done pulse afterwards.
2. Increment wrap and saturation:
   - Stimulus: ld 0xFF, inc.
   - Required response: SATURATE=0 gives out=0x00, carry=1, zero=1; SATURATE=1 gives out=0xFF, carry=1.
3. Decrement borrow:
   - Stimulus: ld 0x00, dec.
   - Required response: SATURATE=0 gives out=0xFF, carry=1; SATURATE=1 gives out=0x00, carry=1.
4. Multi-cycle left shift:
   - Stimulus: ld 0x81, sl amt=3 rot=0 il=1, with il driven 0 after acceptance.
   - Required response: out 0x03, 0x07, 0x0F on successive edges; busy high for 2 cycles; carry=0 at end; one-cycle done; final out=0x0F.
5. Right rotate:
   - Stimulus: ld 0x01, sr amt=7 rot=1.
   - Required response: final out=0x02, carry=0; done pulses once, 7 edges after acceptance.
6. Priority and abort:
   - Stimulus A: ld 0x3C, sl amt=6; assert cl and inc together at step 2.
   - Required response A: out=0x00, busy=0, no done pulse.
   - Stimulus B: assert ld and inc together in IDLE.
   - Required response B: ld wins. amt=0 gives done=1 one cycle later with out unchanged.

Source files
------------

// File: rtl/multi_shift_register.sv
// Width-generic accumulator/shift register with clear, load, inc/dec (optional clamp)
// and multi-bit shifts/rotates executed one bit per clock with a busy/done handshake.
module multi_shift_register #(
    parameter int WIDTH    = 8,
    parameter int AMT_W    = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cl,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic             sr,
    input  logic             sl,
    input  logic             rot,
    input  logic             ir,
    input  logic             il,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_out;
    logic               r_carry;
    logic               r_busy;
    logic               r_done;
    logic [AMT_W-1:0]   r_rem;
    logic               r_left;
    logic               r_rot;
    logic               r_fill;

    logic               w_new_left;
    logic               w_new_fill;
    logic [WIDTH:0]     w_step_new;
    logic [WIDTH:0]     w_step_cont;
    logic [WIDTH:0]     w_inc;
    logic [WIDTH:0]     w_dec;
    logic               w_all_ones;
    logic               w_is_zero;

    // One single-bit step; result is {shifted-out bit, new value}.
    function automatic logic [WIDTH:0] step_bit(input logic [WIDTH-1:0] v,
                                                input logic left,
                                                input logic do_rot,
                                                input logic fill);
        logic f;
        if (left) begin
            f = do_rot ? v[WIDTH-1] : fill;
            return {v[WIDTH-1], v[WIDTH-2:0], f};
        end else begin
            f = do_rot ? v[0] : fill;
            return {v[0], f, v[WIDTH-1:1]};
        end
    endfunction

    // sr outranks sl, so a simultaneous request is treated as a right shift.
    assign w_new_left  = ~sr;
    assign w_new_fill  = sr ? ir : il;
    assign w_step_new  = step_bit(r_out, w_new_left, rot, w_new_fill);
    assign w_step_cont = step_bit(r_out, r_left, r_rot, r_fill);

    // The extra top bit doubles as carry (all-ones) and borrow (zero).
    assign w_inc      = {1'b0, r_out} + (WIDTH+1)'(1);
    assign w_dec      = {1'b0, r_out} - (WIDTH+1)'(1);
    assign w_all_ones = &r_out;
    assign w_is_zero  = (r_out == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rem   <= '0;
            r_left  <= 1'b0;
            r_rot   <= 1'b0;
            r_fill  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cl) begin
                        r_out   <= '0;
                        r_carry <= 1'b0;
                    end else if (ld) begin
                        r_out   <= in;
                        r_carry <= 1'b0;
                    end else if (inc) begin
                        if (SATURATE != 0 && w_all_ones) begin
                            r_carry <= 1'b1;
                        end else begin
                            {r_carry, r_out} <= w_inc;
                        end
                    end else if (dec) begin
                        if (SATURATE != 0 && w_is_zero) begin
                            r_carry <= 1'b1;
                        end else begin
                            {r_carry, r_out} <= w_dec;
                        end
                    end else if (sr || sl) begin
                        if (amt == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            {r_carry, r_out} <= w_step_new;
                            if (amt == AMT_W'(1)) begin
                                r_done <= 1'b1;
                            end else begin
                                r_rem   <= amt - AMT_W'(1);
                                r_left  <= w_new_left;
                                r_rot   <= rot;
                                r_fill  <= w_new_fill;
                                r_busy  <= 1'b1;
                                r_state <= SHIFT;
                            end
                        end
                    end
                end
                SHIFT: begin
                    if (cl) begin
                        r_out   <= '0;
                        r_carry <= 1'b0;
                        r_busy  <= 1'b0;
                        r_rem   <= '0;
                        r_state <= IDLE;
                    end else begin
                        {r_carry, r_out} <= w_step_cont;
                        r_rem <= r_rem - AMT_W'(1);
                        if (r_rem == AMT_W'(1)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out   = r_out;
    assign carry = r_carry;
    assign zero  = (r_out == '0);
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_multi_shift_register.sv
// Directed bench for multi_shift_register: a wrapping and a saturating instance
// share one stimulus stream and are compared against hand-computed values.
module tb_multi_shift_register;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cl, ld, inc, dec, sr, sl, rot, ir, il;
    logic [2:0] amt;
    logic [7:0] in;

    logic [7:0] out_w, out_s;
    logic       carry_w, zero_w, busy_w, done_w;
    logic       carry_s, zero_s, busy_s, done_s;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_shift_register #(.WIDTH(8), .AMT_W(3), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .inc(inc), .dec(dec),
        .sr(sr), .sl(sl), .rot(rot), .ir(ir), .il(il), .amt(amt), .in(in),
        .out(out_w), .carry(carry_w), .zero(zero_w), .busy(busy_w), .done(done_w)
    );

    multi_shift_register #(.WIDTH(8), .AMT_W(3), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .inc(inc), .dec(dec),
        .sr(sr), .sl(sl), .rot(rot), .ir(ir), .il(il), .amt(amt), .in(in),
        .out(out_s), .carry(carry_s), .zero(zero_s), .busy(busy_s), .done(done_s)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle_cmds();
        cl = 0; ld = 0; inc = 0; dec = 0; sr = 0; sl = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        idle_cmds();
        ld = 1; in = v;
        tick();
        ld = 0;
    endtask

    int done_cnt;
    int done_at;

    initial begin
        rst_n = 0;
        idle_cmds();
        rot = 0; ir = 0; il = 0; amt = 0; in = 0;
        tick();
        check("rst_out",   out_w,   8'h00);
        check("rst_flags", {carry_w, busy_w, done_w, zero_w}, 4'b0001);
        rst_n = 1;
        tick();

        // Test 1: asynchronous reset in the middle of a shift
        load(8'hA5);
        sr = 1; amt = 3'd5; rot = 0; ir = 0;
        tick();
        idle_cmds();
        check("t1_accept_out", out_w, 8'h52);
        check("t1_busy", busy_w, 1'b1);
        tick();
        #2 rst_n = 0;
        #1;
        check("t1_rst_out", out_w, 8'h00);
        check("t1_rst_flags", {carry_w, busy_w, done_w, zero_w}, 4'b0001);
        tick();
        tick();
        rst_n = 1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done_w) done_cnt++;
        end
        check("t1_no_done", done_cnt[7:0], 8'd0);
        check("t1_out_after", out_w, 8'h00);

        // Test 2: increment wrap vs clamp, plus an ordinary increment
        load(8'hFF);
        inc = 1;
        tick();
        idle_cmds();
        check("t2_wrap_out", out_w, 8'h00);
        check("t2_wrap_cz", {carry_w, zero_w}, 2'b11);
        check("t2_sat_out", out_s, 8'hFF);
        check("t2_sat_cz", {carry_s, zero_s}, 2'b10);
        load(8'h7F);
        inc = 1;
        tick();
        idle_cmds();
        check("t2_inc_out", {out_w, out_s}, 16'h8080);
        check("t2_inc_c", {carry_w, carry_s}, 2'b00);

        // Test 3: decrement borrow vs clamp
        load(8'h00);
        dec = 1;
        tick();
        idle_cmds();
        check("t3_wrap_out", out_w, 8'hFF);
        check("t3_wrap_c", carry_w, 1'b1);
        check("t3_sat_out", out_s, 8'h00);
        check("t3_sat_cz", {carry_s, zero_s}, 2'b11);

        // Test 4: three-step left shift, fill bit changed after acceptance
        load(8'h81);
        sl = 1; amt = 3'd3; rot = 0; il = 1;
        tick();
        idle_cmds();
        il = 0;
        check("t4_s1", {out_w, 7'd0, busy_w}, {8'h03, 7'd0, 1'b1});
        check("t4_s1_c", carry_w, 1'b1);
        tick();
        check("t4_s2", {out_w, 7'd0, busy_w}, {8'h07, 7'd0, 1'b1});
        tick();
        check("t4_s3", {out_w, 7'd0, busy_w}, {8'h0F, 7'd0, 1'b0});
        check("t4_end", {carry_w, done_w}, 2'b01);
        tick();
        check("t4_done_drop", {out_w, 7'd0, done_w}, {8'h0F, 8'h00});

        // Test 5: rotate right by 7 == rotate left by 1
        load(8'h01);
        sr = 1; amt = 3'd7; rot = 1;
        done_cnt = 0;
        done_at  = 0;
        tick();
        idle_cmds();
        rot = 0;
        for (int e = 1; e <= 10; e++) begin
            if (done_w) begin
                done_cnt++;
                done_at = e;
            end
            if (e == 7) begin
                check("t5_out", out_w, 8'h02);
                check("t5_c", carry_w, 1'b0);
            end
            tick();
        end
        check("t5_done_cnt", done_cnt[7:0], 8'd1);
        check("t5_done_at", done_at[7:0], 8'd7);
        check("t5_hold", out_w, 8'h02);

        // Test 6A: clear with inc aborts a shift in progress
        load(8'h3C);
        sl = 1; amt = 3'd6; il = 0;
        tick();
        idle_cmds();
        check("t6a_s1", out_w, 8'h78);
        cl = 1; inc = 1;
        tick();
        idle_cmds();
        check("t6a_abort", {out_w, 5'd0, busy_w, done_w, carry_w}, {8'h00, 8'h00});
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_w || busy_w) done_cnt++;
        end
        check("t6a_quiet", {out_w, done_cnt[7:0]}, 16'h0000);

        // Load during a shift is neither applied nor queued
        load(8'h01);
        sr = 1; amt = 3'd2; ir = 0; rot = 0;
        tick();
        idle_cmds();
        ld = 1; in = 8'hFF;
        tick();
        idle_cmds();
        check("t6_ld_ignored", {out_w, 7'd0, done_w}, {8'h00, 8'h01});
        tick();
        check("t6_ld_not_queued", out_w, 8'h00);

        // Test 6B: ld beats inc; zero-count shift only pulses done
        ld = 1; inc = 1; in = 8'h5A;
        tick();
        idle_cmds();
        check("t6b_ld_wins", {out_w, 7'd0, carry_w}, {8'h5A, 8'h00});
        sr = 1; amt = 3'd0;
        tick();
        idle_cmds();
        check("t6b_amt0", {out_w, 6'd0, busy_w, done_w}, {8'h5A, 8'h01});
        tick();
        check("t6b_done_drop", {out_w, 7'd0, done_w}, {8'h5A, 8'h00});

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
